// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite channel bundle; the master drives requests and the slave drives ready/response.
interface axi4_lite_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 32,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;

    logic [ADDR_BIT_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_BIT_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDR_BIT_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_BIT_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite register file: NUM_REGS word registers with byte strobes, independent AW/W
// holding registers, one write and one read in flight, and per-register write pulses.
module axi4_lite_slv_reg_file #(
    parameter int unsigned ADDR_BIT_WIDTH = 32,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    axi4_lite_if.slv_port                      axi,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                reg_wr_pulse
);
    localparam int unsigned STRB_W      = DATA_BIT_WIDTH / 8;
    localparam int unsigned LSB         = $clog2(STRB_W);
    localparam int unsigned IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                              aw_held_q, aw_held_d;
    logic [ADDR_BIT_WIDTH-1:0]         awaddr_q, awaddr_d;
    logic                              w_held_q, w_held_d;
    logic [DATA_BIT_WIDTH-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]                 wstrb_q, wstrb_d;
    logic                              awready_q, awready_d;
    logic                              wready_q, wready_d;
    logic                              arready_q, arready_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic                              rvalid_q, rvalid_d;
    logic [DATA_BIT_WIDTH-1:0]         rdata_q, rdata_d;
    logic [1:0]                        rresp_q, rresp_d;
    logic [NUM_REGS*DATA_BIT_WIDTH-1:0] reg_d;
    logic [NUM_REGS-1:0]               wr_pulse_d;

    logic                              aw_hs_c, w_hs_c, ar_hs_c, commit_c;
    logic                              wr_in_range_c, rd_in_range_c;
    logic [IDX_W-1:0]                  wr_idx_c, rd_idx_c;
    logic [DATA_BIT_WIDTH-1:0]         rd_word_c;
    logic                              unused_prot;

    // Any bit set at or above the word index range makes the access out of range.
    function automatic logic addr_in_range(input logic [ADDR_BIT_WIDTH-1:0] addr);
        return (addr >> LSB) < ADDR_BIT_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_BIT_WIDTH-1:0] addr);
        return IDX_W'(addr >> LSB);
    endfunction

    assign unused_prot = ^{axi.awprot, axi.arprot};

    assign aw_hs_c       = axi.awvalid && awready_q;
    assign w_hs_c        = axi.wvalid && wready_q;
    assign ar_hs_c       = axi.arvalid && arready_q;
    assign commit_c      = aw_held_q && w_held_q && (!bvalid_q || axi.bready);
    assign wr_in_range_c = addr_in_range(awaddr_q);
    assign wr_idx_c      = addr_index(awaddr_q);
    assign rd_in_range_c = addr_in_range(axi.araddr);
    assign rd_idx_c      = addr_index(axi.araddr);

    // Write path: capture AW/W independently, commit once both are held and B is free.
    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        reg_d      = reg_q;
        wr_pulse_d = '0;

        if (aw_hs_c) begin
            aw_held_d = 1'b1;
            awaddr_d  = axi.awaddr;
        end
        if (w_hs_c) begin
            w_held_d = 1'b1;
            wdata_d  = axi.wdata;
            wstrb_d  = axi.wstrb;
        end
        if (bvalid_q && axi.bready) begin
            bvalid_d = 1'b0;
        end
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_in_range_c && (wr_idx_c == IDX_W'(i))) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            reg_d[i*DATA_BIT_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end

        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
    end

    // Read path: sample the addressed register on the AR handshake, hold until R handshake.
    always_comb begin
        rd_word_c = '0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_in_range_c && (rd_idx_c == IDX_W'(i))) begin
                rd_word_c = reg_q[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            end
        end

        if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word_c;
            rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end

        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q    <= 1'b0;
            awaddr_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            reg_q        <= '0;
            reg_wr_pulse <= '0;
        end else begin
            aw_held_q    <= aw_held_d;
            awaddr_q     <= awaddr_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            arready_q    <= arready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            reg_q        <= reg_d;
            reg_wr_pulse <= wr_pulse_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Self-checking bench for axi4_lite_slv_reg_file against an array-based register model.
module tb_axi4_lite_slv_reg_file;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]  reg_wr_pulse;
    int             tests_run    = 0;
    int             tests_failed = 0;
    int             cycle        = 0;
    logic [DW-1:0]  mdl [NR];

    axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi_if ();

    axi4_lite_slv_reg_file #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .axi(axi_if), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: word-addressed array, byte strobes, anything past reg 7 is an error.
    function automatic bit mdl_in_range(input logic [31:0] a);
        return (a / 4) < NR;
    endfunction

    function automatic int mdl_index(input logic [31:0] a);
        return int'(a / 4);
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!mdl_in_range(a)) return;
        for (int b = 0; b < 4; b++) if (s[b]) mdl[mdl_index(a)][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [NR*DW-1:0] mdl_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    function automatic logic [NR-1:0] mdl_pulse(input logic [31:0] a);
        return mdl_in_range(a) ? (NR'(1) << mdl_index(a)) : '0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic [NR-1:0] pulse,
                             output logic [NR-1:0] pulse_after, output logic bvalid_after,
                             output int lat, output bit to);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int n = 0, acc;
        to = 0; resp = '0; pulse = '0; pulse_after = '0; bvalid_after = 0; lat = -1;
        axi_if.awaddr = addr; axi_if.wdata = data; axi_if.wstrb = strb;
        axi_if.awprot = 3'($urandom);
        while (!(aw_done && w_done) && n < 100) begin
            axi_if.awvalid = !aw_done && (n >= aw_dly);
            axi_if.wvalid  = !w_done && (n >= w_dly);
            aw_fire = axi_if.awvalid && axi_if.awready;
            w_fire  = axi_if.wvalid && axi_if.wready;
            tick();
            n++;
            aw_done |= aw_fire;
            w_done  |= w_fire;
        end
        axi_if.awvalid = 0; axi_if.wvalid = 0;
        acc = cycle;
        n = 0;
        while (!axi_if.bvalid && n < 20) begin tick(); n++; end
        if (!axi_if.bvalid || !(aw_done && w_done)) to = 1;
        else begin
            lat = cycle - acc; resp = axi_if.bresp; pulse = reg_wr_pulse;
            axi_if.bready = 1; tick();
            pulse_after = reg_wr_pulse; bvalid_after = axi_if.bvalid;
            axi_if.bready = 0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic rvalid_after, output int lat, output bit to);
        bit fire = 0;
        int n = 0;
        to = 0; data = '0; resp = '0; rvalid_after = 0; lat = -1;
        axi_if.araddr = addr; axi_if.arprot = 3'($urandom);
        while (!fire && n < 50) begin
            axi_if.arvalid = 1; fire = axi_if.arready; tick(); n++;
        end
        axi_if.arvalid = 0;
        n = 0;
        while (!axi_if.rvalid && n < 20) begin tick(); n++; end
        if (!axi_if.rvalid || !fire) to = 1;
        else begin
            lat = n; data = axi_if.rdata; resp = axi_if.rresp;
            axi_if.rready = 1; tick();
            rvalid_after = axi_if.rvalid;
            axi_if.rready = 0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        tests_run++;
        if ({axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid, axi_if.rvalid} !== 5'b0 ||
            {axi_if.bresp, axi_if.rresp} !== 4'b0 || axi_if.rdata !== '0 || reg_q !== '0 || reg_wr_pulse !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: ready/valid=%b resp=%b rdata=%h reg_q=%h pulse=%b required all zero",
                     {axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid, axi_if.rvalid},
                     {axi_if.bresp, axi_if.rresp}, axi_if.rdata, reg_q, reg_wr_pulse);
        end
        repeat (3) tick();
        rst_n = 1;
        #1;
        tests_run++;
        if ({axi_if.awready, axi_if.wready, axi_if.arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ready_before_edge: got %b required 000", {axi_if.awready, axi_if.wready, axi_if.arready});
        end
        tick();
        tests_run++;
        if ({axi_if.awready, axi_if.wready, axi_if.arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL ready_after_edge: got %b required 111", {axi_if.awready, axi_if.wready, axi_if.arready});
        end
        for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to; logic [31:0] rd;
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, resp, p, pa, va, lat, to);
        mdl_write(32'h04, 32'hDEADBEEF, 4'hF);
        tests_run++;
        if (to || lat !== 1 || resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_bresp: timeout=%0d lat=%0d resp=%b required lat=1 resp=00", to, lat, resp);
        end
        tests_run++;
        if (p !== 8'b0000_0010 || pa !== '0 || va !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pulse: pulse=%b next=%b bvalid_next=%b required 00000010/0/0", p, pa, va);
        end
        tests_run++;
        if (reg_q !== mdl_flat()) begin
            tests_failed++;
            $display("FAIL basic_reg_q: got %h required %h", reg_q, mdl_flat());
        end
        axi_read(32'h04, rd, resp, va, lat, to);
        tests_run++;
        if (to || rd !== 32'hDEADBEEF || resp !== 2'b00 || lat !== 0 || va !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_read: timeout=%0d rdata=%h rresp=%b lat=%0d required deadbeef/00/0", to, rd, resp, lat);
        end
    endtask

    task automatic test_strobe_order();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to;
        for (int pass = 0; pass < 2; pass++) begin
            axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, resp, p, pa, va, lat, to);
            mdl_write(32'h08, 32'hFFFFFFFF, 4'hF);
            axi_write(32'h08, 32'h11223344, 4'h5, (pass == 0) ? 3 : 0, (pass == 0) ? 0 : 3,
                      resp, p, pa, va, lat, to);
            mdl_write(32'h08, 32'h11223344, 4'h5);
            tests_run++;
            if (to || resp !== 2'b00 || va !== 1'b0 || p !== 8'b0000_0100 ||
                reg_q[2*DW +: DW] !== 32'hFF22FF44 || reg_q !== mdl_flat()) begin
                tests_failed++;
                $display("FAIL strobe_order_%0d: timeout=%0d resp=%b bvalid_next=%b pulse=%b reg2=%h required 00/0/00000100/ff22ff44",
                         pass, to, resp, va, p, reg_q[2*DW +: DW]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to; logic [31:0] rd;
        logic [31:0] addrs [2];
        addrs[0] = 32'h20; addrs[1] = 32'h8000_0004;
        for (int k = 0; k < 2; k++) begin
            axi_write(addrs[k], $urandom, 4'hF, 0, 0, resp, p, pa, va, lat, to);
            tests_run++;
            if (to || resp !== 2'b10 || p !== '0 || reg_q !== mdl_flat()) begin
                tests_failed++;
                $display("FAIL oor_write_%h: timeout=%0d resp=%b pulse=%b reg_q=%h required 10/0/%h",
                         addrs[k], to, resp, p, reg_q, mdl_flat());
            end
            axi_read(addrs[k], rd, resp, va, lat, to);
            tests_run++;
            if (to || rd !== 32'h0 || resp !== 2'b10) begin
                tests_failed++;
                $display("FAIL oor_read_%h: timeout=%0d rdata=%h rresp=%b required 0/10", addrs[k], to, rd, resp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] da = $urandom, db = $urandom, old4;
        old4 = mdl[4];
        axi_if.awaddr = 32'h0C; axi_if.wdata = da; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1; axi_if.wvalid = 1;
        tick();
        axi_if.awaddr = 32'h10; axi_if.wdata = db;
        tick();
        tick();
        axi_if.awvalid = 0; axi_if.wvalid = 0;
        mdl_write(32'h0C, da, 4'hF);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (axi_if.awready !== 0 || axi_if.wready !== 0 || axi_if.bvalid !== 1 ||
                axi_if.bresp !== 2'b00 || reg_q[4*DW +: DW] !== old4 || reg_q[3*DW +: DW] !== da) begin
                tests_failed++;
                $display("FAIL bp_stall_%0d: awready=%b wready=%b bvalid=%b reg4=%h reg3=%h required 0/0/1/%h/%h",
                         c, axi_if.awready, axi_if.wready, axi_if.bvalid, reg_q[4*DW +: DW], reg_q[3*DW +: DW], old4, da);
            end
            tick();
        end
        axi_if.bready = 1;
        tick();
        mdl_write(32'h10, db, 4'hF);
        tests_run++;
        if (axi_if.bvalid !== 1 || reg_q !== mdl_flat() || reg_wr_pulse !== 8'b0001_0000) begin
            tests_failed++;
            $display("FAIL bp_second_commit: bvalid=%b reg4=%h pulse=%b required 1/%h/00010000",
                     axi_if.bvalid, reg_q[4*DW +: DW], reg_wr_pulse, db);
        end
        tick();
        axi_if.bready = 0;
        tests_run++;
        if (axi_if.bvalid !== 0) begin
            tests_failed++;
            $display("FAIL bp_drain: bvalid=%b required 0", axi_if.bvalid);
        end
    endtask

    task automatic test_read_stall();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to; logic [31:0] d = $urandom, rd;
        axi_write(32'h14, d, 4'hF, 0, 0, resp, p, pa, va, lat, to);
        mdl_write(32'h14, d, 4'hF);
        axi_if.araddr = 32'h14; axi_if.arvalid = 1;
        tick();
        axi_if.arvalid = 0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (axi_if.rvalid !== 1 || axi_if.rdata !== mdl[5] || axi_if.rresp !== 2'b00 || axi_if.arready !== 0) begin
                tests_failed++;
                $display("FAIL rd_stall_%0d: rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/00/0",
                         c, axi_if.rvalid, axi_if.rdata, axi_if.rresp, axi_if.arready, mdl[5]);
            end
            tick();
        end
        axi_if.rready = 1; tick(); axi_if.rready = 0; tick();
        tests_run++;
        if (axi_if.rvalid !== 0 || axi_if.arready !== 1) begin
            tests_failed++;
            $display("FAIL rd_release: rvalid=%b arready=%b required 0/1", axi_if.rvalid, axi_if.arready);
        end
        // Same-edge read and write of reg 0.
        axi_write(32'h00, 32'h1, 4'hF, 0, 0, resp, p, pa, va, lat, to);
        axi_if.awaddr = 32'h00; axi_if.wdata = 32'h2; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1; axi_if.wvalid = 1;
        tick();
        axi_if.awvalid = 0; axi_if.wvalid = 0;
        axi_if.araddr = 32'h00; axi_if.arvalid = 1;
        tick();
        axi_if.arvalid = 0;
        tests_run++;
        if (axi_if.rvalid !== 1 || axi_if.rdata !== 32'h1 || axi_if.bvalid !== 1 || reg_q[DW-1:0] !== 32'h2) begin
            tests_failed++;
            $display("FAIL same_edge: rvalid=%b rdata=%h bvalid=%b reg0=%h required 1/00000001/1/00000002",
                     axi_if.rvalid, axi_if.rdata, axi_if.bvalid, reg_q[DW-1:0]);
        end
        axi_if.rready = 1; axi_if.bready = 1; tick(); axi_if.rready = 0; axi_if.bready = 0;
        mdl[0] = 32'h2;
        axi_read(32'h00, rd, resp, va, lat, to);
        tests_run++;
        if (to || rd !== 32'h2 || resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL same_edge_reread: timeout=%0d rdata=%h required 00000002", to, rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc [4]; int k = 0, n = 0; bit fire; logic [31:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        axi_if.bready = 1;
        axi_if.awaddr = 32'h14; axi_if.wdata = d[0]; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1; axi_if.wvalid = 1;
        while (k < 4 && n < 40) begin
            fire = axi_if.awready && axi_if.wready;
            tick(); n++;
            if (fire) begin
                mdl_write(32'h14 + 32'(4*k), d[k], 4'hF);
                acc[k] = cycle; k++;
                if (k < 4) begin axi_if.awaddr = 32'h14 + 32'(4*k); axi_if.wdata = d[k]; end
            end
        end
        axi_if.awvalid = 0; axi_if.wvalid = 0;
        tick(); tick();
        axi_if.bready = 0;
        tests_run++;
        if (k !== 4 || acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2 || acc[3] - acc[2] !== 2 ||
            reg_q !== mdl_flat() || axi_if.bvalid !== 0) begin
            tests_failed++;
            $display("FAIL b2b_write: accepted=%0d gaps=%0d,%0d,%0d reg_q=%h required 4/2,2,2/%h",
                     k, acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2], reg_q, mdl_flat());
        end
        k = 0; n = 0;
        axi_if.rready = 1; axi_if.araddr = 32'h14; axi_if.arvalid = 1;
        while (k < 4 && n < 40) begin
            fire = axi_if.arready;
            tick(); n++;
            if (fire) begin
                acc[k] = cycle;
                tests_run++;
                if (axi_if.rvalid !== 1 || axi_if.rdata !== mdl[(5 + k) % NR]) begin
                    tests_failed++;
                    $display("FAIL b2b_read_%0d: rvalid=%b rdata=%h required 1/%h", k, axi_if.rvalid, axi_if.rdata, mdl[(5 + k) % NR]);
                end
                k++;
                axi_if.araddr = 32'((4 * (5 + k)) % 32);
            end
        end
        axi_if.arvalid = 0; tick(); axi_if.rready = 0;
        tests_run++;
        if (k !== 4 || acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2 || acc[3] - acc[2] !== 2) begin
            tests_failed++;
            $display("FAIL b2b_read_rate: accepted=%0d gaps=%0d,%0d,%0d required 4/2,2,2",
                     k, acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to; logic [31:0] rd, d = $urandom;
        axi_if.awaddr = 32'h18; axi_if.wdata = $urandom; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1; axi_if.wvalid = 1; tick();
        axi_if.awvalid = 0; axi_if.wvalid = 0; tick();
        axi_if.araddr = 32'h18; axi_if.arvalid = 1; axi_if.awaddr = 32'h1C; axi_if.awvalid = 1; tick();
        axi_if.arvalid = 0; axi_if.awvalid = 0;
        #2 rst_n = 0;
        #1;
        tests_run++;
        if ({axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid, axi_if.rvalid} !== 5'b0 ||
            {axi_if.bresp, axi_if.rresp} !== 4'b0 || axi_if.rdata !== '0 || reg_q !== '0 || reg_wr_pulse !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_values: ready/valid=%b resp=%b rdata=%h reg_q=%h required all zero",
                     {axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid, axi_if.rvalid},
                     {axi_if.bresp, axi_if.rresp}, axi_if.rdata, reg_q);
        end
        for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
        tick(); tick();
        rst_n = 1;
        axi_if.bready = 1; axi_if.rready = 1;
        tick(); tick(); tick();
        tests_run++;
        if (axi_if.bvalid !== 0 || axi_if.rvalid !== 0 || reg_q !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_stale: bvalid=%b rvalid=%b reg_q=%h required 0/0/0", axi_if.bvalid, axi_if.rvalid, reg_q);
        end
        axi_if.bready = 0; axi_if.rready = 0;
        axi_write(32'h1C, d, 4'hF, 1, 0, resp, p, pa, va, lat, to);
        mdl_write(32'h1C, d, 4'hF);
        axi_read(32'h1C, rd, resp, va, lat, to);
        tests_run++;
        if (to || rd !== d || resp !== 2'b00 || reg_q !== mdl_flat()) begin
            tests_failed++;
            $display("FAIL mid_reset_fresh: timeout=%0d rdata=%h rresp=%b required %h/00", to, rd, resp, d);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [NR-1:0] p, pa; logic va; int lat; bit to; logic [31:0] a, d, rd; logic [3:0] s;
        for (int op = 0; op < 120; op++) begin
            case ($urandom_range(0, 9))
                8:       a = 32'h20 + 32'($urandom_range(0, 31));
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom);
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, p, pa, va, lat, to);
                tests_run++;
                if (to || lat !== 1 || resp !== (mdl_in_range(a) ? 2'b00 : 2'b10) || p !== mdl_pulse(a)) begin
                    tests_failed++;
                    $display("FAIL rand_write_%0d addr=%h: timeout=%0d lat=%0d resp=%b pulse=%b required lat=1 resp=%b pulse=%b",
                             op, a, to, lat, resp, p, mdl_in_range(a) ? 2'b00 : 2'b10, mdl_pulse(a));
                end
                mdl_write(a, d, s);
                tests_run++;
                if (reg_q !== mdl_flat()) begin
                    tests_failed++;
                    $display("FAIL rand_reg_q_%0d: got %h required %h", op, reg_q, mdl_flat());
                end
            end else begin
                axi_read(a, rd, resp, va, lat, to);
                tests_run++;
                if (to || rd !== (mdl_in_range(a) ? mdl[mdl_index(a)] : 32'h0) ||
                    resp !== (mdl_in_range(a) ? 2'b00 : 2'b10)) begin
                    tests_failed++;
                    $display("FAIL rand_read_%0d addr=%h: timeout=%0d rdata=%h rresp=%b required %h/%b", op, a, to, rd, resp,
                             mdl_in_range(a) ? mdl[mdl_index(a)] : 32'h0, mdl_in_range(a) ? 2'b00 : 2'b10);
                end
            end
        end
    endtask

    initial begin
        axi_if.awaddr = '0; axi_if.awprot = '0; axi_if.awvalid = 0;
        axi_if.wdata = '0; axi_if.wstrb = '0; axi_if.wvalid = 0; axi_if.bready = 0;
        axi_if.araddr = '0; axi_if.arprot = '0; axi_if.arvalid = 0; axi_if.rready = 0;
        test_reset();
        test_basic();
        test_strobe_order();
        test_out_of_range();
        test_backpressure();
        test_read_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
